bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of bus requesters (2..8).
REQ-002 SHALL have parameter START_TIMEOUT, default 15, max cycles from grant to begin_transactionIN.
REQ-003 SHALL have parameter WATCHDOG_CYCLES, default 1023, max cycles of one transaction (watchdog build only).
REQ-004 SHALL have port system_clock  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port system_reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port request  in  NUM_MASTERS  per-master bus request, level.
REQ-007 SHALL have port granted  out  NUM_MASTERS  one-hot or zero grant, registered.
REQ-008 SHALL have port begin_transactionIN  in  1  bus begin strobe from granted master.
REQ-009 SHALL have port end_transactionIN  in  1  bus end strobe (master or slave).
REQ-010 SHALL have port errorIN  in  1  bus error strobe.
REQ-011 SHALL have port end_transactionOUT  out  1  arbiter-forced end strobe.
REQ-012 SHALL have port errorOUT  out  1  arbiter-forced error strobe.
REQ-013 SHALL have port active_master  out  3  index of granted master, 0 when none.
REQ-014 SHALL have port bus_idle  out  1  high in IDLE only.

Function
REQ-015 SHALL implement states IDLE, GRANTED, BUSY, RELEASE, registered.
REQ-016 IDLE: if any request bit high, SHALL assert granted for exactly one master on the next edge and move to GRANTED.
REQ-017 Selection SHALL be round-robin: first requesting index at or after rr_ptr, wrapping modulo NUM_MASTERS.
REQ-018 On each grant SHALL set rr_ptr to (winner+1) mod NUM_MASTERS.
REQ-019 GRANTED: begin_transactionIN SHALL move to BUSY; granted master dropping request SHALL move to RELEASE; START_TIMEOUT cycles without begin SHALL move to RELEASE.
REQ-020 BUSY: end_transactionIN or errorIN SHALL move to RELEASE; request changes SHALL be ignored.
REQ-021 begin_transactionIN and end_transactionIN in the same GRANTED cycle SHALL move directly to RELEASE.
REQ-022 RELEASE SHALL last exactly one cycle with granted=0, then IDLE; minimum gap between grants is 2 cycles.
REQ-023 granted SHALL go to zero on the edge that enters RELEASE.
REQ-024 begin/end/error strobes in IDLE or RELEASE SHALL be ignored.
REQ-025 Timeout counter SHALL be 8 bits, cleared on entering GRANTED, saturating.
REQ-026 active_master SHALL equal the encoded granted index; bus_idle SHALL be high only in IDLE.

Reset
REQ-027 On system_reset high at an edge: state IDLE, granted=0, rr_ptr=0, counters=0, active_master=0, bus_idle=1, end_transactionOUT=0, errorOUT=0.
REQ-028 Reset mid-transaction SHALL drop granted on that edge with no forced end strobe.

Configuration
REQ-029 With ARBITER_WATCHDOG_EN defined: 10-bit counter runs in BUSY; reaching WATCHDOG_CYCLES SHALL pulse end_transactionOUT and errorOUT for one cycle and enter RELEASE.
REQ-030 Without ARBITER_WATCHDOG_EN: no watchdog counter; end_transactionOUT and errorOUT SHALL be constant 0; BUSY waits indefinitely.

Structure
REQ-031 State encoding, counter widths and MAX_MASTERS=8 SHALL live in shared package bus_arbiter_pkg.
REQ-032 Round-robin selection SHALL be sub-module rr_select (combinational: request, rr_ptr -> one-hot winner, valid).

Verification
REQ-033 Reset, request=4'b0101 -> granted=4'b0001 one cycle later, active_master=0, bus_idle=0.
REQ-034 Master0 begin then end after 5 cycles, request=4'b0101 held -> RELEASE 1 cycle, then granted=4'b0100.
REQ-035 All four requesting continuously, each transaction 3 cycles -> grant order 0,1,2,3,0.
REQ-036 Grant to master1, no begin for 15 cycles -> granted=0 on the 16th edge, next grant to master2 if requesting.
REQ-037 Watchdog build, BUSY 1023 cycles without end -> end_transactionOUT=errorOUT=1 for one cycle, granted=0.
REQ-038 system_reset during BUSY of master3 -> granted=0 next edge, next grant restarts from master0.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared arbiter definitions: FSM encoding, counter widths, master limit, index encoder.
// No logic of its own, so no latency.
// No flow control; imported by bus_arbiter and rr_select.
package bus_arbiter_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int IDX_W       = 3;
    localparam int TO_CNT_W    = 8;
    localparam int WD_CNT_W    = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // Encode a one-hot (or zero) vector to its bit index; zero maps to 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Round-robin pick: first requester at or after the pointer, wrapping to index 0.
// Purely combinational, zero latency.
// No backpressure; o_valid is low when nothing is requesting.
module rr_select
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] i_request,
    input  logic [IDX_W-1:0]       i_rr_ptr,
    output logic [NUM_MASTERS-1:0] o_winner,
    output logic                   o_valid
);

    // Two passes: indices from the pointer upwards, then the wrapped low indices.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!o_valid && i_request[i] && (i >= int'(i_rr_ptr))) begin
                o_winner[i] = 1'b1;
                o_valid     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!o_valid && i_request[i]) begin
                o_winner[i] = 1'b1;
                o_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with start timeout; optional BUSY watchdog under ARBITER_WATCHDOG_EN.
// Grant registered one cycle after request seen in IDLE; one RELEASE cycle between grants.
// No backpressure: masters hold request level, bus strobes are single-cycle and sampled in-state.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int START_TIMEOUT   = 15,
    parameter int WATCHDOG_CYCLES = 1023
) (
    input  logic                   system_clock,
    input  logic                   system_reset,
    input  logic [NUM_MASTERS-1:0] request,
    output logic [NUM_MASTERS-1:0] granted,
    input  logic                   begin_transactionIN,
    input  logic                   end_transactionIN,
    input  logic                   errorIN,
    output logic                   end_transactionOUT,
    output logic                   errorOUT,
    output logic [2:0]             active_master,
    output logic                   bus_idle
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(START_TIMEOUT - 1);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [NUM_MASTERS-1:0]  r_granted;
    logic [NUM_MASTERS-1:0]  w_granted_nxt;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        w_rr_ptr_nxt;
    logic [TO_CNT_W-1:0]     r_to_cnt;
    logic [TO_CNT_W-1:0]     w_to_cnt_nxt;
    logic [NUM_MASTERS-1:0]  w_sel_onehot;
    logic                    w_sel_vld;
    logic [IDX_W-1:0]        w_win_idx;
    logic                    w_req_held;
    logic                    w_wd_expire;

    rr_select #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_select (
        .i_request (request),
        .i_rr_ptr  (r_rr_ptr),
        .o_winner  (w_sel_onehot),
        .o_valid   (w_sel_vld)
    );

    assign w_win_idx  = onehot_to_idx(MAX_MASTERS'(w_sel_onehot));
    assign w_req_held = |(request & r_granted);

`ifdef ARBITER_WATCHDOG_EN
    logic [WD_CNT_W-1:0] r_wd_cnt;
    logic                r_wd_pulse;

    assign w_wd_expire = (r_state == ST_BUSY) &&
                         (r_wd_cnt == WD_CNT_W'(WATCHDOG_CYCLES - 1));

    // Count BUSY cycles; the forced strobes line up with the RELEASE cycle.
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            r_wd_cnt   <= '0;
            r_wd_pulse <= 1'b0;
        end else begin
            r_wd_pulse <= w_wd_expire;
            if ((r_state == ST_BUSY) && !w_wd_expire) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    assign end_transactionOUT = r_wd_pulse;
    assign errorOUT           = r_wd_pulse;
`else
    assign w_wd_expire        = 1'b0;
    assign end_transactionOUT = 1'b0;
    assign errorOUT           = 1'b0;
`endif

    // Next-state, grant vector, round-robin pointer and start-timeout counter.
    always_comb begin
        w_state_nxt   = r_state;
        w_granted_nxt = r_granted;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_to_cnt_nxt  = r_to_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_vld) begin
                    w_state_nxt   = ST_GRANTED;
                    w_granted_nxt = w_sel_onehot;
                    w_rr_ptr_nxt  = (w_win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_win_idx + 1'b1;
                    w_to_cnt_nxt  = '0;
                end
            end
            ST_GRANTED: begin
                // begin wins over a simultaneous request drop; begin+end is a zero-length transfer
                if (begin_transactionIN && end_transactionIN) begin
                    w_state_nxt   = ST_RELEASE;
                    w_granted_nxt = '0;
                end else if (begin_transactionIN) begin
                    w_state_nxt = ST_BUSY;
                end else if (!w_req_held || (r_to_cnt >= TO_LAST)) begin
                    w_state_nxt   = ST_RELEASE;
                    w_granted_nxt = '0;
                end else if (r_to_cnt != '1) begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            ST_BUSY: begin
                if (end_transactionIN || errorIN || w_wd_expire) begin
                    w_state_nxt   = ST_RELEASE;
                    w_granted_nxt = '0;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_granted_nxt = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops the grant with no forced strobe.
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            r_state   <= ST_IDLE;
            r_granted <= '0;
            r_rr_ptr  <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_granted <= w_granted_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end

    assign granted       = r_granted;
    assign active_master = onehot_to_idx(MAX_MASTERS'(r_granted));
    assign bus_idle      = (r_state == ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: transaction-level model of winner, grant length and gap.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Watchdog behaviour checked according to ARBITER_WATCHDOG_EN.
module tb_bus_arbiter;

    localparam int K_NORMAL  = 0;
    localparam int K_ERROR   = 1;
    localparam int K_NOBEGIN = 2;
    localparam int K_DROP    = 3;
    localparam int K_SAME    = 4;
    localparam int K_HANG    = 5;

    logic       clk = 1'b0;
    logic       system_reset;
    logic [3:0] request;
    logic [3:0] granted;
    logic       begin_in, end_in, err_in;
    logic       end_out, err_out;
    logic [2:0] active_master;
    logic       bus_idle;

    int n_chk  = 0;
    int n_pass = 0;
    int m_ptr  = 0;

    bus_arbiter #(
        .NUM_MASTERS     (4),
        .START_TIMEOUT   (15),
        .WATCHDOG_CYCLES (1023)
    ) dut (
        .system_clock        (clk),
        .system_reset        (system_reset),
        .request             (request),
        .granted             (granted),
        .begin_transactionIN (begin_in),
        .end_transactionIN   (end_in),
        .errorIN             (err_in),
        .end_transactionOUT  (end_out),
        .errorOUT            (err_out),
        .active_master       (active_master),
        .bus_idle            (bus_idle)
    );

    always #5 clk = ~clk;

    // Reference: first requester at or after ptr, modulo 4; -1 if none.
    function automatic int pick(input logic [3:0] req, input int ptr);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (ptr + k) % 4;
            if (((req >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    // Reference: number of cycles granted stays high for each scenario.
    function automatic int exp_hi(input int kind, input int d, input int len);
        case (kind)
            K_NORMAL, K_ERROR: return d + 2 + len;
            K_NOBEGIN:         return 15;
            default:           return d + 1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        system_reset = 1'b1;
        request = 4'b0; begin_in = 1'b0; end_in = 1'b0; err_in = 1'b0;
        step();
        system_reset = 1'b0;
        m_ptr = 0;
    endtask

    // Drives one transaction and measures it; performs no comparisons itself.
    task automatic run_txn(input int kind, input int d, input int len, input bit scramble,
                           input bit gap_strobe, output logic [3:0] win, output int hi,
                           output int gap, output logic [2:0] act, output bit ok);
        int c;
        ok = 1'b1; gap = 0; hi = 0; win = 4'b0; act = 3'b0;
        while (granted === 4'b0 && gap < 64) begin
            begin_in = gap_strobe; end_in = gap_strobe; err_in = gap_strobe;
            step();
            gap++;
        end
        begin_in = 1'b0; end_in = 1'b0; err_in = 1'b0;
        if (granted === 4'b0) begin
            ok = 1'b0;
            return;
        end
        win = granted;
        act = active_master;
        c = 0;
        while (granted === win && hi < 3000) begin
            begin_in = 1'b0; end_in = 1'b0; err_in = 1'b0;
            case (kind)
                K_NORMAL: begin
                    if (c == d) begin_in = 1'b1;
                    if (c == d + 1 + len) end_in = 1'b1;
                end
                K_ERROR: begin
                    if (c == d) begin_in = 1'b1;
                    if (c == d + 1 + len) err_in = 1'b1;
                end
                K_DROP:  if (c == d) request = request & ~win;
                K_SAME:  if (c == d) begin begin_in = 1'b1; end_in = 1'b1; end
                K_HANG:  if (c == d) begin_in = 1'b1;
                default: ;
            endcase
            if (scramble && c > d && (kind == K_NORMAL || kind == K_ERROR)) request = 4'($urandom);
            step();
            c++;
            hi++;
        end
        begin_in = 1'b0; end_in = 1'b0; err_in = 1'b0;
        if (granted !== 4'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        system_reset = 1'b1;
        request = 4'b1111; begin_in = 1'b1; end_in = 1'b1; err_in = 1'b1;
        step();
        n_chk++; if (granted !== 4'b0) $display("FAIL reset_granted got=%b exp=0000", granted); else n_pass++;
        n_chk++; if (active_master !== 3'd0) $display("FAIL reset_active got=%0d exp=0", active_master); else n_pass++;
        n_chk++; if (bus_idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", bus_idle); else n_pass++;
        n_chk++; if (end_out !== 1'b0) $display("FAIL reset_end_out got=%b exp=0", end_out); else n_pass++;
        n_chk++; if (err_out !== 1'b0) $display("FAIL reset_err_out got=%b exp=0", err_out); else n_pass++;
        system_reset = 1'b0;
        request = 4'b0; begin_in = 1'b0; end_in = 1'b0; err_in = 1'b0;
        m_ptr = 0;
        step();
    endtask

    task automatic test_first_grant();
        int e;
        request = 4'b0101;
        e = pick(request, m_ptr);
        step();
        n_chk++; if (granted !== 4'(1 << e)) $display("FAIL first_grant got=%b exp=%b", granted, 4'(1 << e)); else n_pass++;
        n_chk++; if (active_master !== 3'(e)) $display("FAIL first_active got=%0d exp=%0d", active_master, e); else n_pass++;
        n_chk++; if (bus_idle !== 1'b0) $display("FAIL first_idle got=%b exp=0", bus_idle); else n_pass++;
        m_ptr = (e + 1) % 4;
    endtask

    task automatic test_release_gap();
        logic [3:0] win; int hi, gap, e; logic [2:0] act; bit ok;
        run_txn(K_NORMAL, 0, 4, 1'b0, 1'b0, win, hi, gap, act, ok);
        n_chk++; if (!ok || hi !== exp_hi(K_NORMAL, 0, 4)) $display("FAIL rel_len got=%0d exp=%0d ok=%0d", hi, exp_hi(K_NORMAL, 0, 4), ok); else n_pass++;
        n_chk++; if (bus_idle !== 1'b0) $display("FAIL rel_not_idle got=%b exp=0", bus_idle); else n_pass++;
        e = pick(request, m_ptr);
        run_txn(K_SAME, 0, 0, 1'b0, 1'b0, win, hi, gap, act, ok);
        n_chk++; if (!ok || win !== 4'(1 << e)) $display("FAIL rel_next_win got=%b exp=%b", win, 4'(1 << e)); else n_pass++;
        n_chk++; if (gap !== 2) $display("FAIL rel_gap got=%0d exp=2", gap); else n_pass++;
        n_chk++; if (hi !== exp_hi(K_SAME, 0, 0)) $display("FAIL same_cycle_len got=%0d exp=%0d", hi, exp_hi(K_SAME, 0, 0)); else n_pass++;
        m_ptr = (e + 1) % 4;
    endtask

    task automatic test_round_robin();
        logic [3:0] win; int hi, gap, e; logic [2:0] act; bit ok;
        do_reset();
        request = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            e = pick(request, m_ptr);
            run_txn(K_NORMAL, 0, 1, 1'b0, 1'b0, win, hi, gap, act, ok);
            n_chk++; if (!ok || win !== 4'(1 << e)) $display("FAIL rr_win[%0d] got=%b exp=%b", i, win, 4'(1 << e)); else n_pass++;
            n_chk++; if (act !== 3'(e)) $display("FAIL rr_active[%0d] got=%0d exp=%0d", i, act, e); else n_pass++;
            n_chk++; if (hi !== 3) $display("FAIL rr_len[%0d] got=%0d exp=3", i, hi); else n_pass++;
            if (i > 0) begin
                n_chk++; if (gap !== 2) $display("FAIL rr_gap[%0d] got=%0d exp=2", i, gap); else n_pass++;
            end
            m_ptr = (e + 1) % 4;
        end
    endtask

    task automatic test_timeout();
        logic [3:0] win; int hi, gap, e; logic [2:0] act; bit ok;
        do_reset();
        request = 4'b0110;
        e = pick(request, m_ptr);
        run_txn(K_NOBEGIN, 0, 0, 1'b0, 1'b0, win, hi, gap, act, ok);
        n_chk++; if (!ok || win !== 4'(1 << e)) $display("FAIL to_win got=%b exp=%b", win, 4'(1 << e)); else n_pass++;
        n_chk++; if (hi !== 15) $display("FAIL to_len got=%0d exp=15", hi); else n_pass++;
        m_ptr = (e + 1) % 4;
        e = pick(request, m_ptr);
        run_txn(K_SAME, 0, 0, 1'b0, 1'b0, win, hi, gap, act, ok);
        n_chk++; if (!ok || win !== 4'(1 << e)) $display("FAIL to_next_win got=%b exp=%b", win, 4'(1 << e)); else n_pass++;
        n_chk++; if (gap !== 2) $display("FAIL to_gap got=%0d exp=2", gap); else n_pass++;
        m_ptr = (e + 1) % 4;
    endtask

    task automatic test_drop();
        logic [3:0] win; int hi, gap, e; logic [2:0] act; bit ok;
        request = 4'b1001;
        e = pick(request, m_ptr);
        run_txn(K_DROP, 3, 0, 1'b0, 1'b0, win, hi, gap, act, ok);
        n_chk++; if (!ok || win !== 4'(1 << e)) $display("FAIL drop_win got=%b exp=%b", win, 4'(1 << e)); else n_pass++;
        n_chk++; if (hi !== exp_hi(K_DROP, 3, 0)) $display("FAIL drop_len got=%0d exp=%0d", hi, exp_hi(K_DROP, 3, 0)); else n_pass++;
        m_ptr = (e + 1) % 4;
        e = pick(request, m_ptr);
        run_txn(K_SAME, 0, 0, 1'b0, 1'b0, win, hi, gap, act, ok);
        n_chk++; if (!ok || win !== 4'(1 << e)) $display("FAIL drop_next_win got=%b exp=%b", win, 4'(1 << e)); else n_pass++;
        m_ptr = (e + 1) % 4;
    endtask

    task automatic test_idle_strobes();
        logic [3:0] win; int hi, gap, e; logic [2:0] act; bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            begin_in = 1'b1; end_in = 1'b1; err_in = 1'b1;
            step();
            n_chk++; if (granted !== 4'b0 || bus_idle !== 1'b1) $display("FAIL idle_strobe[%0d] got=%b/%b exp=0000/1", i, granted, bus_idle); else n_pass++;
        end
        request = 4'b0001;
        e = pick(request, m_ptr);
        run_txn(K_NOBEGIN, 0, 0, 1'b0, 1'b1, win, hi, gap, act, ok);
        n_chk++; if (!ok || hi !== 15) $display("FAIL idle_begin_ignored got=%0d exp=15", hi); else n_pass++;
        m_ptr = (e + 1) % 4;
        e = pick(request, m_ptr);
        run_txn(K_NOBEGIN, 0, 0, 1'b0, 1'b1, win, hi, gap, act, ok);
        n_chk++; if (!ok || hi !== 15 || gap !== 2) $display("FAIL release_begin_ignored got=%0d/%0d exp=15/2", hi, gap); else n_pass++;
        m_ptr = (e + 1) % 4;
    endtask

    task automatic test_random();
        logic [3:0] win, req; int hi, gap, e, kind, d, len; logic [2:0] act; bit ok;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 4);
            d    = $urandom_range(0, 13);
            len  = $urandom_range(0, 20);
            req  = 4'($urandom_range(1, 15));
            request = req;
            e = pick(req, m_ptr);
            run_txn(kind, d, len, 1'b1, 1'($urandom_range(0, 1)), win, hi, gap, act, ok);
            n_chk++;
            if (!ok || win !== 4'(1 << e) || act !== 3'(e) || hi !== exp_hi(kind, d, len) || (i > 0 && gap !== 2))
                $display("FAIL rand[%0d] kind=%0d win=%b/%b act=%0d/%0d len=%0d/%0d gap=%0d ok=%0d",
                         i, kind, win, 4'(1 << e), act, e, hi, exp_hi(kind, d, len), gap, ok);
            else n_pass++;
            m_ptr = (e + 1) % 4;
        end
    endtask

    task automatic test_watchdog();
`ifdef ARBITER_WATCHDOG_EN
        logic [3:0] win; int hi, gap; logic [2:0] act; bit ok;
        do_reset();
        request = 4'b0001;
        run_txn(K_HANG, 0, 0, 1'b0, 1'b0, win, hi, gap, act, ok);
        n_chk++; if (!ok || hi !== 1 + 1023) $display("FAIL wd_len got=%0d exp=%0d", hi, 1 + 1023); else n_pass++;
        n_chk++; if (end_out !== 1'b1 || err_out !== 1'b1) $display("FAIL wd_pulse got=%b%b exp=11", end_out, err_out); else n_pass++;
        step();
        n_chk++; if (end_out !== 1'b0 || err_out !== 1'b0) $display("FAIL wd_pulse_end got=%b%b exp=00", end_out, err_out); else n_pass++;
`else
        int bad;
        do_reset();
        request = 4'b0001;
        step();
        n_chk++; if (granted !== 4'b0001) $display("FAIL nowd_grant got=%b exp=0001", granted); else n_pass++;
        begin_in = 1'b1;
        step();
        begin_in = 1'b0;
        bad = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (granted !== 4'b0001 || end_out !== 1'b0 || err_out !== 1'b0) bad++;
        end
        n_chk++; if (bad != 0) $display("FAIL nowd_busy_hold got=%0d bad cycles exp=0", bad); else n_pass++;
`endif
    endtask

    task automatic test_reset_busy();
        int w;
        do_reset();
        request = 4'b1000;
        w = 0;
        while (granted === 4'b0 && w < 20) begin step(); w++; end
        n_chk++; if (granted !== 4'b1000) $display("FAIL rb_grant got=%b exp=1000", granted); else n_pass++;
        begin_in = 1'b1;
        step();
        begin_in = 1'b0;
        for (int i = 0; i < 5; i++) begin request = 4'($urandom); step(); end
        n_chk++; if (granted !== 4'b1000) $display("FAIL rb_busy_hold got=%b exp=1000", granted); else n_pass++;
        system_reset = 1'b1;
        step();
        n_chk++; if (granted !== 4'b0 || active_master !== 3'd0) $display("FAIL rb_drop got=%b/%0d exp=0000/0", granted, active_master); else n_pass++;
        n_chk++; if (end_out !== 1'b0 || err_out !== 1'b0) $display("FAIL rb_no_strobe got=%b%b exp=00", end_out, err_out); else n_pass++;
        n_chk++; if (bus_idle !== 1'b1) $display("FAIL rb_idle got=%b exp=1", bus_idle); else n_pass++;
        system_reset = 1'b0;
        request = 4'b1111;
        m_ptr = 0;
        step();
        n_chk++; if (granted !== 4'(1 << pick(4'b1111, m_ptr))) $display("FAIL rb_restart got=%b exp=0001", granted); else n_pass++;
    endtask

    initial begin
        system_reset = 1'b1;
        request = 4'b0; begin_in = 1'b0; end_in = 1'b0; err_in = 1'b0;
        step();
        test_reset();
        test_first_grant();
        test_release_gap();
        test_round_robin();
        test_timeout();
        test_drop();
        test_idle_strobes();
        test_random();
        test_watchdog();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
